output_uart_tx: RTL and testbench
=================================

# output_uart_tx

Serial transmitter for the CPU output port: the receiving end of the CPU's `Output_Ld`/`OutReg` write interface. Each CPU output write is captured into a small FIFO and sent as two 8N1 UART frames, high byte first, on `Tx`. The block sits beside the CPU at top level and drives an FPGA pin. It decouples CPU execution speed from the serial rate and flags writes lost to a full buffer.

## Interface
- `DataWidth`, 16, CPU output port width; fixed at 16 (two bytes per word).
- `FifoDepthLog2`, 2, log2 of FIFO depth in words (default 4 words).
- `ClksPerBit`, 16, `Clk` cycles per serial bit; must be ≥ 2.

Ports:
- `Clk` input 1 — system clock, shared with the CPU.
- `Reset` input 1 — asynchronous, active-high reset; one clock domain only.
- `Output_Ld` input 1 — CPU output-register load strobe.
- `OutReg` input DataWidth — CPU output register contents.
- `Tx` output 1 — serial line; idles high.
- `Busy` output 1 — high while a frame is in progress or the FIFO is non-empty.
- `Full` output 1 — FIFO holds 2^FifoDepthLog2 words.
- `Overflow` output 1 — sticky; set when a write is dropped; cleared only by `Reset`.

## Operation
- Capture:
  - `OutReg` updates on the edge at which `Output_Ld` is sampled high.
  - The block therefore registers `Output_Ld` into `ld_d`.
  - In the cycle `ld_d` = 1, it pushes the `OutReg` value present in that cycle.
- Push acceptance:
  - A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `Overflow` is set.
  - Push and pop in the same cycle leave the count unchanged; data order is preserved.
- FIFO: circular buffer with read/write pointers of FifoDepthLog2 bits (wrapping modulo depth) and a count of FifoDepthLog2+1 bits.
- FSM states:
  - IDLE: `Tx` = 1. If the FIFO is non-empty, pop the word, latch it into a 16-bit hold register, set `byte_sel` = HIGH, load the baud counter, and go to START.
  - START: `Tx` = 0 for ClksPerBit cycles, then go to DATA with bit index 0.
  - DATA: `Tx` = current byte bit[index], sent LSB first. Each bit lasts ClksPerBit cycles. After bit 7, go to STOP.
  - STOP: `Tx` = 1 for ClksPerBit cycles. Then:
    - if `byte_sel` = HIGH: set `byte_sel` = LOW and go to START;
    - otherwise go to IDLE.
- IDLE pops on the first cycle it observes a non-empty FIFO. There is no extra idle bit between words beyond the one stop bit per byte.
- Baud counter:
  - Loads ClksPerBit-1 on each state or bit entry and decrements to 0.
  - The transition occurs on the cycle it reads 0.
  - Width is $clog2(ClksPerBit).
- Current byte = hold[15:8] when `byte_sel` = HIGH, else hold[7:0].

## Timing
- Reset values:
  - `Tx` = 1, `Busy` = 0, `Full` = 0, `Overflow` = 0.
  - FSM in IDLE; count, pointers and `ld_d` = 0; hold = 0.
- Latency: `Output_Ld` high in cycle 0 → `ld_d` = 1 and push in cycle 1 → FIFO non-empty and pop in cycle 2 → `Tx` = 0 from cycle 3.
- Word duration: 20 × ClksPerBit cycles, from `Tx` falling for the high byte to the end of the low byte's stop bit.
- Back-to-back: if the FIFO is non-empty when STOP of the low byte ends, IDLE lasts exactly one cycle (`Tx` = 1) before the next START.
- `Busy` = (state ≠ IDLE) | (count ≠ 0), registered from next-state. It rises in cycle 2 of the latency sequence above.
- `Full` is combinational from count.
- Reset asserted mid-frame: `Tx` returns to 1 immediately (asynchronous). All buffered words are discarded and the partial frame is not resumed.
- `Output_Ld` held high for k cycles produces k pushes, all of the same `OutReg` value after the first edge.

## Structure
- Shared constants file (alongside the sequence-control constants): FSM state encodings (IDLE, START, DATA, STOP), `TX_IDLE` level = 1, and byte-select encodings HIGH/LOW.
- One sub-module, `word_fifo`:
  - Parameterised by DataWidth and FifoDepthLog2.
  - Ports: Clk, Reset, Push, Pop, DIn, DOut, Empty, Full, Count.
  - Async active-high reset.
- The FSM, baud counter, shift/bit index, `ld_d` and `Overflow` live in `output_uart_tx`.

## Test plan
- Reset check: hold `Reset` for 3 cycles with `Output_Ld` = 0 → `Tx` = 1, `Busy`/`Full`/`Overflow` = 0, and they stay so for 100 cycles.
- Single word:
  - Setup: ClksPerBit = 4; pulse `Output_Ld` for 1 cycle, then `OutReg` = 0xA55A.
  - `Tx` falls at cycle 3.
  - Sampled bits: 0, 1,0,1,0,0,1,0,1, 1, then 0, 0,1,0,1,1,0,1,0, 1.
  - `Busy` drops 80 cycles after `Tx` falls.
- Back-to-back: two writes, 0x1234 then 0xBEEF, 2 cycles apart → decoded bytes 0x12, 0x34, 0xBE, 0xEF. Exactly one idle-high cycle between the two words.
- Overflow:
  - Setup: FifoDepthLog2 = 2; issue 6 writes on consecutive cycles (0x0001..0x0006).
  - First pop occurs before write 6 is captured: words 1–5 transmitted; `Full` asserts.
  - Write 6 is dropped; `Overflow` = 1 and remains 1 after transmission completes.
- Full plus simultaneous pop: fill the FIFO while IDLE is about to pop, then push in the pop cycle → push accepted, count unchanged, `Overflow` stays 0.
- Mid-frame reset: assert `Reset` during DATA of the high byte → `Tx` = 1 in the same cycle. After release, no residual frames are sent and a new write transmits correctly.

Source files
------------

// File: rtl/output_uart_tx_pkg.sv
// Shared constants for the CPU output-port serial transmitter:
// transmitter FSM states, idle line level and byte-select codes.
package output_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic {
    BYTE_LOW  = 1'b0,
    BYTE_HIGH = 1'b1
  } byte_sel_t;

  localparam logic TX_IDLE = 1'b1;
  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/output_uart_tx_word_fifo.sv
// Circular word buffer between CPU output writes and the transmitter.
// Ports: Clk, Reset (async high), Push, Pop, DIn, DOut, Empty, Full, Count.
module word_fifo
  import output_uart_tx_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int FifoDepthLog2 = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Push,
  input  logic                   Pop,
  input  logic [DataWidth-1:0]   DIn,
  output logic [DataWidth-1:0]   DOut,
  output logic                   Empty,
  output logic                   Full,
  output logic [FifoDepthLog2:0] Count
);

  localparam int Depth = 1 << FifoDepthLog2;
  localparam logic [FifoDepthLog2:0] DepthCnt =
    {1'b1, {FifoDepthLog2{1'b0}}};

  logic [DataWidth-1:0]     r_mem [Depth];
  logic [FifoDepthLog2-1:0] r_wr_ptr;
  logic [FifoDepthLog2-1:0] r_rd_ptr;
  logic [FifoDepthLog2:0]   r_count;
  logic                     w_do_pop;
  logic                     w_do_push;

  assign Empty = (r_count == '0);
  assign Full  = (r_count == DepthCnt);
  assign Count = r_count;
  assign DOut  = r_mem[r_rd_ptr];

  assign w_do_pop  = Pop & ~Empty;
  // When full, a same-cycle pop frees the slot the write lands in;
  // the read sees the old word because the write commits at the edge.
  assign w_do_push = Push & (~Full | w_do_pop);

  always_ff @(posedge Clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= DIn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/output_uart_tx.sv
// CPU output port to UART: buffers each write, sends it as two 8N1 bytes.
// Ports: Clk, Reset, Output_Ld, OutReg in; Tx, Busy, Full, Overflow out.
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter int DataWidth     = 16,
  parameter int FifoDepthLog2 = 2,
  parameter int ClksPerBit    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Output_Ld,
  input  logic [DataWidth-1:0] OutReg,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Full,
  output logic                 Overflow
);

  localparam int BaudW = $clog2(ClksPerBit);
  localparam logic [BaudW-1:0] BaudLoad = BaudW'(ClksPerBit - 1);

  tx_state_t              r_state, w_state_nxt;
  byte_sel_t              r_byte_sel, w_byte_sel_nxt;
  logic [BaudW-1:0]       r_baud, w_baud_nxt;
  logic [2:0]             r_bit_idx, w_bit_idx_nxt;
  logic [DataWidth-1:0]   r_hold, w_hold_nxt;
  logic                   r_ld_d;
  logic                   r_overflow;
  logic                   r_busy;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_empty;
  logic                   w_full;
  logic [FifoDepthLog2:0] w_count;
  logic [FifoDepthLog2:0] w_count_nxt;
  logic [DataWidth-1:0]   w_dout;
  logic [7:0]             w_cur_byte;

  // OutReg changes on the edge that samples Output_Ld, so the
  // word is taken one cycle later from the delayed strobe.
  assign w_push = r_ld_d & (~w_full | w_pop);

  word_fifo #(
    .DataWidth     (DataWidth),
    .FifoDepthLog2 (FifoDepthLog2)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .Push  (w_push),
    .Pop   (w_pop),
    .DIn   (OutReg),
    .DOut  (w_dout),
    .Empty (w_empty),
    .Full  (w_full),
    .Count (w_count)
  );

  always_comb begin
    w_count_nxt = w_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = w_count + 1'b1;
      2'b01:   w_count_nxt = w_count - 1'b1;
      default: w_count_nxt = w_count;
    endcase
  end

  assign w_cur_byte = (r_byte_sel == BYTE_HIGH) ? r_hold[15:8]
                                                : r_hold[7:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_sel_nxt = r_byte_sel;
    w_baud_nxt     = r_baud;
    w_bit_idx_nxt  = r_bit_idx;
    w_hold_nxt     = r_hold;
    w_pop          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_hold_nxt     = w_dout;
          w_byte_sel_nxt = BYTE_HIGH;
          w_baud_nxt     = BaudLoad;
          w_state_nxt    = ST_START;
        end
      end
      ST_START: begin
        if (r_baud == '0) begin
          w_baud_nxt    = BaudLoad;
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      ST_DATA: begin
        if (r_baud == '0) begin
          w_baud_nxt = BaudLoad;
          if (r_bit_idx == 3'(BITS_PER_BYTE - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      ST_STOP: begin
        if (r_baud == '0) begin
          if (r_byte_sel == BYTE_HIGH) begin
            w_byte_sel_nxt = BYTE_LOW;
            w_baud_nxt     = BaudLoad;
            w_state_nxt    = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tx decodes registered state only, so reset forces it high at once.
  always_comb begin
    Tx = TX_IDLE;
    unique case (r_state)
      ST_IDLE:  Tx = TX_IDLE;
      ST_START: Tx = 1'b0;
      ST_DATA:  Tx = w_cur_byte[r_bit_idx];
      ST_STOP:  Tx = 1'b1;
      default:  Tx = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_byte_sel <= BYTE_HIGH;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_hold     <= '0;
      r_ld_d     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_hold     <= w_hold_nxt;
      r_ld_d     <= Output_Ld;
      if (r_ld_d && !w_push) r_overflow <= 1'b1;
      r_busy <= (w_state_nxt != ST_IDLE) | (w_count_nxt != '0);
    end
  end

  assign Busy     = r_busy;
  assign Full     = w_full;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: frame-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_output_uart_tx;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 20 * CPB;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Output_Ld = 1'b0;
  logic [15:0] OutReg = 16'h0000;
  logic        Tx, Busy, Full, Overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  output_uart_tx #(
    .DataWidth     (16),
    .FifoDepthLog2 (DL2),
    .ClksPerBit    (CPB)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Output_Ld (Output_Ld),
    .OutReg    (OutReg),
    .Tx        (Tx),
    .Busy      (Busy),
    .Full      (Full),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Line image of one word: start, high byte LSB first, stop,
  // start, low byte LSB first, stop. Element 0 goes out first.
  function automatic logic [19:0] frame(logic [15:0] w);
    return {1'b1, w[7:0], 1'b0, 1'b1, w[15:8], 1'b0};
  endfunction

  // Model: queue of pending words; a word leaves the queue on the
  // first cycle the line is free and owns the next FRAME cycles.
  logic [15:0] q[$];
  logic [19:0] m_fb;
  int          m_fs;
  bit          m_act;
  bit          m_ovf;
  bit          m_prev_ld;
  int          m_free;

  always @(negedge Clk) begin
    int t;
    logic e_tx;
    logic e_busy;
    t = cyc;
    if (Reset) begin
      chk("rst_tx", Tx, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_full", Full, 0);
      chk("rst_ovf", Overflow, 0);
      q.delete();
      m_act = 0;
      m_ovf = 0;
      m_prev_ld = 0;
      m_free = 0;
    end else begin
      e_tx = 1'b1;
      if (m_act && t >= m_fs && t < m_fs + FRAME)
        e_tx = m_fb[(t - m_fs) / CPB];
      e_busy = (q.size() > 0) || (m_act && t < m_fs + FRAME);
      chk("m_tx", Tx, e_tx);
      chk("m_busy", Busy, e_busy);
      chk("m_full", Full, q.size() == DEPTH);
      chk("m_ovf", Overflow, m_ovf);
      if (t >= m_free && q.size() > 0) begin
        m_fb   = frame(q.pop_front());
        m_fs   = t + 1;
        m_act  = 1;
        m_free = t + 1 + FRAME;
      end
      if (m_prev_ld) begin
        if (q.size() < DEPTH) q.push_back(OutReg);
        else m_ovf = 1;
      end
      m_prev_ld = Output_Ld;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // CPU-style write: strobe this cycle, register value next cycle.
  task automatic write(logic [15:0] v);
    Output_Ld = 1'b1;
    tick(1);
    Output_Ld = 1'b0;
    OutReg = v;
  endtask

  task automatic wait_fall(output int f);
    bit ok;
    ok = 0;
    f = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (Tx === 1'b0) begin
        ok = 1;
        f = cyc;
        break;
      end
    end
    chk("tx_fall_seen", ok, 1);
  endtask

  task automatic capture(output logic [19:0] b, output int f);
    b = '1;
    wait_fall(f);
    if (f >= 0) begin
      for (int i = 0; i < 20; i++) begin
        repeat ((i == 0) ? CPB / 2 : CPB) @(negedge Clk);
        b[i] = Tx;
      end
    end
  endtask

  task automatic wait_idle(int lim, output int d);
    bit ok;
    ok = 0;
    d = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge Clk);
      if (Busy === 1'b0) begin
        ok = 1;
        d = cyc;
        break;
      end
    end
    chk("busy_drop_seen", ok, 1);
  endtask

  initial begin
    int c, f, f2, d;
    logic [19:0] b, b2;

    // Reset, then quiet line
    tick(3);
    Reset = 1'b0;
    repeat (100) @(negedge Clk);
    chk("idle_tx", Tx, 1);
    chk("idle_busy", Busy, 0);
    chk("idle_full", Full, 0);
    chk("idle_ovf", Overflow, 0);

    // Single word
    chk("model_pin", frame(16'hA55A), 20'b1_01011010_0_1_10100101_0);
    tick(1);
    c = cyc;
    write(16'hA55A);
    capture(b, f);
    chk("fall_latency", f - c, 3);
    chk("a55a_bits", b, 20'b1_01011010_0_1_10100101_0);
    wait_idle(400, d);
    chk("busy_len", d - f, 80);

    // Back-to-back
    tick(1);
    write(16'h1234);
    tick(1);
    write(16'hBEEF);
    capture(b, f);
    capture(b2, f2);
    chk("b2b_byte0", b[8:1], 8'h12);
    chk("b2b_byte1", b[18:11], 8'h34);
    chk("b2b_byte2", b2[8:1], 8'hBE);
    chk("b2b_byte3", b2[18:11], 8'hEF);
    chk("b2b_gap", f2 - f, 81);
    wait_idle(400, d);

    // Overflow: six consecutive writes into a 4-deep buffer
    tick(1);
    Output_Ld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      OutReg = 16'(k);
      Output_Ld = (k < 6);
    end
    @(negedge Clk);
    chk("ovf_full", Full, 1);
    @(negedge Clk);
    chk("ovf_set", Overflow, 1);
    wait_idle(600, d);
    chk("ovf_sticky", Overflow, 1);
    chk("ovf_drained", Full, 0);

    // Mid-frame reset during high-byte data bits
    tick(1);
    write(16'h00FF);
    wait_fall(f);
    tick(10);
    Reset = 1'b1;
    #1;
    chk("async_tx", Tx, 1);
    tick(3);
    Reset = 1'b0;
    tick(100);
    chk("post_rst_busy", Busy, 0);
    chk("post_rst_ovf", Overflow, 0);
    c = cyc;
    write(16'hC3A5);
    capture(b, f);
    chk("rst_fall_lat", f - c, 3);
    chk("rst_hi", b[8:1], 8'hC3);
    chk("rst_lo", b[18:11], 8'hA5);
    wait_idle(400, d);

    // Full buffer with a push landing in the pop cycle
    tick(1);
    Output_Ld = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      OutReg = 16'(k);
      Output_Ld = (k < 5);
    end
    tick(77);
    Output_Ld = 1'b1;
    tick(1);
    Output_Ld = 1'b0;
    OutReg = 16'h0006;
    @(negedge Clk);
    chk("fp_full_pop", Full, 1);
    @(negedge Clk);
    chk("fp_full_kept", Full, 1);
    chk("fp_no_ovf", Overflow, 0);
    chk("fp_next_start", Tx, 0);
    wait_idle(700, d);
    chk("fp_ovf_end", Overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
